// File: rtl/rv32i_pkg.sv
// rv32i_pkg: datapath-wide constants and types shared by the rv32i pipeline stages.
//   DPW     datapath width
//   REG_AW  register-file index width
//   mw_regs_t  contents of the M/W pipeline register bank
package rv32i_pkg;

    localparam int DPW    = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              regwrite;
        logic [REG_AW-1:0] rd;
        logic              resultsrc;
        logic [DPW-1:0]    aluresult;
        logic              misalign;
        // Load data is only meaningful when the access was aligned and
        // was not squashed by reset; otherwise readdataW is forced to 0.
        logic              ld_valid;
    } mw_regs_t;

    function automatic logic is_aligned(input logic [1:0] byte_off);
        return (byte_off == 2'b00);
    endfunction

endpackage

// File: rtl/memory_stage_data_mem.sv
// data_mem: single-port synchronous word RAM.
//   clk    clock
//   we     write enable, word written at the rising edge
//   addr   word index
//   wdata  write data
//   rdata  registered read data, read-first (returns the old word on a
//          same-cycle write to the same index)
// The array has no reset.
module data_mem #(
    parameter int DEPTH = 256,
    parameter int DPW   = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DPW-1:0]           wdata,
    output logic [DPW-1:0]           rdata
);

    logic [DPW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: memory + writeback-register stage of the rv32i pipeline.
//   clk         clock
//   rst         synchronous active-high reset
//   regwriteM   M-stage register write enable
//   resultsrcM  0: ALU result, 1: load data
//   memwriteM   store Rd2M to memory
//   aluresultM  byte address for loads/stores, ALU result otherwise
//   Rd2M        store data
//   RdM         destination register index
//   regwriteW   registered write enable toward the register file
//   RdW         registered destination index
//   resultW     writeback value (combinational mux of W registers)
//   misalignW   registered flag: the load/store in W was not word aligned
module memory_stage
    import rv32i_pkg::*;
#(
    parameter int DMEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwriteM,
    input  logic              resultsrcM,
    input  logic              memwriteM,
    input  logic [DPW-1:0]    aluresultM,
    input  logic [DPW-1:0]    Rd2M,
    input  logic [REG_AW-1:0] RdM,
    output logic              regwriteW,
    output logic [REG_AW-1:0] RdW,
    output logic [DPW-1:0]    resultW,
    output logic              misalignW
);

    localparam int AW = $clog2(DMEM_DEPTH);

    logic [AW-1:0]  widx;
    logic           aligned;
    logic           mem_we;
    logic [DPW-1:0] mem_rdata;
    logic [DPW-1:0] readdataW;

    mw_regs_t w_q;
    mw_regs_t w_d;

    // Upper address bits are dropped, so addresses wrap modulo 4*DMEM_DEPTH.
    assign widx    = aluresultM[AW+1:2];
    assign aligned = is_aligned(aluresultM[1:0]);
    assign mem_we  = memwriteM & aligned & ~rst;

    data_mem #(
        .DEPTH (DMEM_DEPTH),
        .DPW   (DPW)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (widx),
        .wdata (Rd2M),
        .rdata (mem_rdata)
    );

    always_comb begin
        w_d           = '0;
        w_d.regwrite  = regwriteM;
        w_d.rd        = RdM;
        w_d.resultsrc = resultsrcM;
        w_d.aluresult = aluresultM;
        w_d.misalign  = (memwriteM | resultsrcM) & ~aligned;
        w_d.ld_valid  = aligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q <= '0;
        end else begin
            w_q <= w_d;
        end
    end

    // The RAM output register is not reset, so it is gated by ld_valid,
    // which also zeroes misaligned loads.
    assign readdataW = w_q.ld_valid ? mem_rdata : '0;

    assign regwriteW = w_q.regwrite;
    assign RdW       = w_q.rd;
    assign misalignW = w_q.misalign;
    assign resultW   = w_q.resultsrc ? readdataW : w_q.aluresult;

endmodule
